shader_tcache_arbiter: RTL

//  Shares one shader_tcache instance between NUM_LANES shader texel-read lanes and one DMA fill port.

---
 rtl/shader_pkg.sv | 16 +
 rtl/shader_tcache_arbiter_if.sv | 33 +++
 rtl/shader_rr_picker.sv | 29 ++
 rtl/shader_tcache_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/shader_pkg.sv
// Shared types and cache sizing for the shader texture-cache arbiter and its attached cache.
package shader_pkg;

    localparam int unsigned TCACHE_SIZE_DEF = 3;
    localparam int unsigned TCACHE_WIDTH    = 1 << TCACHE_SIZE_DEF;
    localparam int unsigned TCACHE_TEXELS   = TCACHE_WIDTH * TCACHE_WIDTH;

    typedef logic [3:0] texel_t;

    typedef enum logic [2:0] {IDLE, ISSUE, S1, S2, S3} tcarb_state_t;

    function automatic int unsigned tcache_texels(input int unsigned size);
        return 1 << (2 * size);
    endfunction

endpackage

// File: rtl/shader_tcache_arbiter_if.sv
// Requester-side bus of the texture-cache arbiter: texel-read lanes, their responses and the DMA fill port.
interface shader_tcache_arbiter_if
    import shader_pkg::*;
#(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned TCACHE_SIZE = TCACHE_SIZE_DEF
) ();

    localparam int unsigned TEXELS = tcache_texels(TCACHE_SIZE);

    logic [NUM_LANES-1:0]                  lane_valid;
    logic [NUM_LANES-1:0]                  lane_ready;
    logic [NUM_LANES-1:0][TCACHE_SIZE-1:0] lane_tu;
    logic [NUM_LANES-1:0][TCACHE_SIZE-1:0] lane_tv;
    logic [NUM_LANES-1:0]                  resp_valid;
    texel_t                                resp_data;
    logic                                  dma_valid;
    logic                                  dma_ready;
    logic [4*TEXELS-1:0]                   dma_data;
    logic [TEXELS-1:0]                     dma_mask;
    logic                                  dma_done;

    modport master (
        output lane_valid, lane_tu, lane_tv, dma_valid, dma_data, dma_mask,
        input  lane_ready, resp_valid, resp_data, dma_ready, dma_done
    );

    modport slave (
        input  lane_valid, lane_tu, lane_tv, dma_valid, dma_data, dma_mask,
        output lane_ready, resp_valid, resp_data, dma_ready, dma_done
    );

endinterface

// File: rtl/shader_rr_picker.sv
// Combinational round-robin picker: the first requesting lane at or after ptr wins.
module shader_rr_picker #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_LANES-1:0] grant,
    output logic [IDX_W-1:0]     idx,
    output logic                 found
);

    always_comb begin
        int unsigned lane;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        lane  = 0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            lane = (32'(ptr) + k) % NUM_LANES;
            if (!found && req[IDX_W'(lane)]) begin
                found = 1'b1;
                idx   = IDX_W'(lane);
            end
        end
        if (found) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/shader_tcache_arbiter.sv
// Shares one shader_tcache between NUM_LANES texel-read lanes and a DMA fill port, sequencing the
// cache's strobe/one-hot handshake and steering the read result back to the issuing lane.
module shader_tcache_arbiter
    import shader_pkg::*;
#(
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned TCACHE_SIZE  = TCACHE_SIZE_DEF,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned TEXELS      = tcache_texels(TCACHE_SIZE)
) (
    input  logic                     aclk,
    input  logic                     areset,
    shader_tcache_arbiter_if.slave   bus,
    output logic                     tc_strobe,
    output logic                     tc_dma_en,
    output logic [TCACHE_SIZE-1:0]   tc_tu,
    output logic [TCACHE_SIZE-1:0]   tc_tv,
    output logic [4*TEXELS-1:0]      tc_dma_data,
    output logic [TEXELS-1:0]        tc_dma_mask,
    input  texel_t                   tc_rdata
);

    localparam int unsigned IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    tcarb_state_t         state_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [CNT_W-1:0]     starve_q;
    logic [IDX_W-1:0]     owner_q;
    logic                 pend_valid_q;
    logic                 pend_dma_q;
    logic [IDX_W-1:0]     pend_owner_q;

    logic [NUM_LANES-1:0] pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 lane_any;
    logic                 grant_window;
    logic                 force_lane;
    logic                 dma_grant;
    logic                 lane_grant;
    logic [IDX_W-1:0]     rr_next;

    shader_rr_picker #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req   (bus.lane_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (lane_any)
    );

    // S3 doubles as a grant slot so back-to-back operations run every 4 cycles.
    assign grant_window = (state_q == IDLE) || (state_q == S3);
    assign force_lane   = (starve_q == CNT_W'(STARVE_LIMIT)) && lane_any;
    assign dma_grant    = !areset && grant_window && bus.dma_valid && !force_lane;
    assign lane_grant   = !areset && grant_window && lane_any && !dma_grant;
    assign rr_next      = (pick_idx == IDX_W'(NUM_LANES - 1)) ? '0 : pick_idx + 1'b1;

    assign bus.lane_ready = lane_grant ? pick_grant : '0;
    assign bus.dma_ready  = dma_grant;
    assign bus.resp_valid = (pend_valid_q && !pend_dma_q) ? (NUM_LANES'(1) << pend_owner_q) : '0;
    assign bus.resp_data  = tc_rdata;
    assign bus.dma_done   = pend_valid_q && pend_dma_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            tc_strobe    <= 1'b0;
            tc_dma_en    <= 1'b0;
            tc_tu        <= '0;
            tc_tv        <= '0;
            tc_dma_data  <= '0;
            tc_dma_mask  <= '0;
            rr_ptr_q     <= '0;
            starve_q     <= '0;
            owner_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_dma_q   <= 1'b0;
            pend_owner_q <= '0;
        end else begin
            tc_strobe <= 1'b0;
            // Snapshot the finishing operation before a lookahead grant overwrites owner/kind.
            pend_valid_q <= (state_q == S3);
            if (state_q == S3) begin
                pend_dma_q   <= tc_dma_en;
                pend_owner_q <= owner_q;
            end

            if (dma_grant) begin
                tc_dma_en   <= 1'b1;
                tc_dma_data <= bus.dma_data;
                tc_dma_mask <= bus.dma_mask;
                if (lane_any && (starve_q < CNT_W'(STARVE_LIMIT))) starve_q <= starve_q + 1'b1;
            end else if (lane_grant) begin
                tc_dma_en <= 1'b0;
                tc_tu     <= bus.lane_tu[pick_idx];
                tc_tv     <= bus.lane_tv[pick_idx];
                owner_q   <= pick_idx;
                rr_ptr_q  <= rr_next;
                starve_q  <= '0;
            end

            unique case (state_q)
                IDLE, S3: begin
                    if (dma_grant || lane_grant) begin
                        state_q   <= ISSUE;
                        tc_strobe <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE:   state_q <= S1;
                S1:      state_q <= S2;
                S2:      state_q <= S3;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
